// File: rtl/execute_memory_reg.sv
// Execute-to-memory pipeline boundary for the Y86-64 PIPE design: owns the
// OF/SF/ZF condition-code register and the M pipeline register.
module execute_memory_reg #(
    parameter int         W         = 64,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [2:0] STAT_AOK  = 3'd1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   e_stat,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic         e_cnd,
    input  logic [W-1:0] e_valE,
    input  logic [W-1:0] e_valA,
    input  logic [3:0]   e_dstE,
    input  logic [3:0]   e_dstM,
    input  logic [2:0]   e_newcc,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [2:0]   cc,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic [3:0]   M_ifun,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;

    logic       set_cc;
    logic [3:0] dst_e_sel;

    // Flags only change for OPq while no older instruction has faulted.
    assign set_cc = (e_icode == I_OPQ) && (m_stat == STAT_AOK) &&
                    (W_stat == STAT_AOK) && !reset;

    // A cmovXX whose condition failed must not write its destination.
    assign dst_e_sel = ((e_icode == I_RRMOVQ) && !e_cnd) ? RNONE : e_dstE;

    always_ff @(posedge clk) begin
        if (reset) begin
            cc <= 3'b100;
        end else if (set_cc) begin
            cc <= e_newcc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (M_bubble && !M_stall)) begin
            M_stat  <= STAT_AOK;
            M_icode <= NOP_ICODE;
            M_ifun  <= 4'h0;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_ifun  <= e_ifun;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= dst_e_sel;
            M_dstM  <= e_dstM;
        end
    end

endmodule

// File: tb/tb_execute_memory_reg.sv
// Directed bench for execute_memory_reg: a transaction-level model predicts the
// CC and M register contents, checked every cycle plus pinned literal values.
module tb_execute_memory_reg;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } m_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic [2:0]  e_newcc;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic        M_stall;
    logic        M_bubble;
    logic [2:0]  cc;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [3:0]  M_ifun;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    int n_vec  = 0;
    int n_fail = 0;

    execute_memory_reg dut (
        .clk(clk), .reset(reset),
        .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun), .e_cnd(e_cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .e_newcc(e_newcc), .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .cc(cc), .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    m_t         exp_m;
    logic [2:0] exp_cc;
    bit         model_valid = 1'b0;

    function automatic m_t nop_word();
        m_t w;
        w = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, cnd: 1'b0,
              valE: 64'd0, valA: 64'd0, dstE: 4'hF, dstM: 4'hF};
        return w;
    endfunction

    function automatic m_t exec_word();
        m_t w;
        w = '{stat: e_stat, icode: e_icode, ifun: e_ifun, cnd: e_cnd,
              valE: e_valE, valA: e_valA, dstE: e_dstE, dstM: e_dstM};
        // conditional move that is not taken writes no register
        if (e_icode == 4'h2 && e_cnd == 1'b0) w.dstE = 4'hF;
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_cc      = 3'b100;
            exp_m       = nop_word();
            model_valid = 1'b1;
        end else begin
            if (e_icode == 4'h6 && m_stat == 3'd1 && W_stat == 3'd1)
                exp_cc = e_newcc;
            if (M_stall)       exp_m = exp_m;
            else if (M_bubble) exp_m = nop_word();
            else               exp_m = exec_word();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cc",      64'(cc),      64'(exp_cc));
            chk("M_stat",  64'(M_stat),  64'(exp_m.stat));
            chk("M_icode", 64'(M_icode), 64'(exp_m.icode));
            chk("M_ifun",  64'(M_ifun),  64'(exp_m.ifun));
            chk("M_cnd",   64'(M_cnd),   64'(exp_m.cnd));
            chk("M_valE",  M_valE,       exp_m.valE);
            chk("M_valA",  M_valA,       exp_m.valA);
            chk("M_dstE",  64'(M_dstE),  64'(exp_m.dstE));
            chk("M_dstM",  64'(M_dstM),  64'(exp_m.dstM));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic cn, input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm, input logic [2:0] nc);
        e_stat = st; e_icode = ic; e_ifun = fn; e_cnd = cn;
        e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm; e_newcc = nc;
    endtask

    initial begin
        reset = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1;
        // reset during an active OPq load
        set_e(3'd1, 4'h6, 4'h1, 1'b1, 64'h1234, 64'h5, 4'h2, 4'hF, 3'b010);
        tick();
        chk("rst_cc",    64'(cc),      64'h4);
        chk("rst_icode", 64'(M_icode), 64'h1);
        chk("rst_dstE",  64'(M_dstE),  64'hF);
        chk("rst_dstM",  64'(M_dstM),  64'hF);
        chk("rst_stat",  64'(M_stat),  64'h1);
        chk("rst_valE",  M_valE,       64'h0);
        reset = 1'b0;

        // subq, flags cleared then ZF set
        set_e(3'd1, 4'h6, 4'h1, 1'b1, 64'd88, 64'd5, 4'h2, 4'hF, 3'b000);
        tick();
        chk("opq_valE", M_valE, 64'd88);
        chk("opq_cc0",  64'(cc), 64'h0);
        e_newcc = 3'b100;
        tick();
        chk("opq_cc4",  64'(cc), 64'h4);

        // CC inhibit by faulting older stages
        e_newcc = 3'b010; m_stat = 3'd3;
        tick();
        chk("inh_m", 64'(cc), 64'h4);
        m_stat = 3'd1; W_stat = 3'd2;
        tick();
        chk("inh_w", 64'(cc), 64'h4);
        W_stat = 3'd1;
        tick();
        chk("inh_ok", 64'(cc), 64'h2);

        // cmovle not taken / taken, cmovg taken
        set_e(3'd1, 4'h2, 4'h1, 1'b0, 64'h456, 64'h456, 4'h3, 4'hF, 3'b111);
        tick();
        chk("cmov_sq_dstE", 64'(M_dstE), 64'hF);
        chk("cmov_sq_valE", M_valE,      64'h456);
        chk("cmov_sq_cc",   64'(cc),     64'h2);
        e_cnd = 1'b1;
        tick();
        chk("cmov_tk_dstE", 64'(M_dstE), 64'h3);
        set_e(3'd1, 4'h2, 4'h6, 1'b1, 64'h666, 64'h666, 4'h5, 4'hF, 3'b000);
        tick();
        chk("cmovg_dstE", 64'(M_dstE), 64'h5);
        chk("cmovg_cnd",  64'(M_cnd),  64'h1);

        // stall / bubble
        set_e(3'd1, 4'h3, 4'h0, 1'b1, 64'h10, 64'h0, 4'h4, 4'hF, 3'b000);
        tick();
        chk("ld_valE", M_valE, 64'h10);
        M_stall = 1'b1;
        set_e(3'd1, 4'h6, 4'h0, 1'b1, 64'h99, 64'h1, 4'h7, 4'hF, 3'b001);
        tick();
        chk("stall1_valE", M_valE,  64'h10);
        chk("stall1_cc",   64'(cc), 64'h1);
        set_e(3'd1, 4'h6, 4'h3, 1'b1, 64'h77, 64'h2, 4'h8, 4'h9, 3'b011);
        tick();
        chk("stall2_valE", M_valE,  64'h10);
        chk("stall2_cc",   64'(cc), 64'h3);
        M_bubble = 1'b1;
        set_e(3'd1, 4'h5, 4'h0, 1'b1, 64'h55, 64'h3, 4'hF, 4'h6, 3'b000);
        tick();
        chk("stbub_valE",  M_valE,        64'h10);
        chk("stbub_icode", 64'(M_icode),  64'h3);
        M_stall = 1'b0;
        tick();
        chk("bub_icode", 64'(M_icode), 64'h1);
        chk("bub_dstE",  64'(M_dstE),  64'hF);
        chk("bub_valE",  M_valE,       64'h0);
        M_bubble = 1'b0;

        // faulting status latched unchanged; wide signed values pass intact
        set_e(3'd3, 4'h5, 4'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8000_0000_0000_0001,
              4'hF, 4'h6, 3'b000);
        tick();
        chk("adr_stat", 64'(M_stat), 64'h3);
        chk("neg_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("neg_valA", M_valA, 64'h8000_0000_0000_0001);

        // reset overrides a stall
        M_stall = 1'b1; reset = 1'b1;
        tick();
        chk("rst_stall_icode", 64'(M_icode), 64'h1);
        chk("rst_stall_cc",    64'(cc),      64'h4);
        reset = 1'b0; M_stall = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_memory_reg.md
Name: execute_memory_reg

Overview:
- Pipeline boundary directly downstream of the execute stage in the Y86-64 PIPE design.
- Holds the condition-code register (OF/SF/ZF) written by OPq results.
- Latches execute outputs into the M pipeline register consumed by the memory stage.
- Applies the cmovXX destination squash, stall/bubble control, and CC-update inhibition on exceptions.

Parameters:
- W, 64, data width of valE/valA.
- RNONE, 4'hF, "no register" ID.
- NOP_ICODE, 4'h1, icode inserted on bubble.
- STAT_AOK, 3'd1, normal status code (HLT=2, ADR=3, INS=4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; initialises the CC register and the M register.
- e_stat  input  3  status from execute.
- e_icode  input  4  icode from execute.
- e_ifun  input  4  ifun from execute.
- e_cnd  input  1  condition outcome from execute.
- e_valE  input  64  ALU result (signed).
- e_valA  input  64  forwarded valA (signed).
- e_dstE  input  4  E destination register ID.
- e_dstM  input  4  M destination register ID.
- e_newcc  input  3  ALU flags; bit0=OF, bit1=SF, bit2=ZF.
- m_stat  input  3  current memory-stage status (for CC inhibit).
- W_stat  input  3  current write-back status (for CC inhibit).
- M_stall  input  1  hold M register.
- M_bubble  input  1  load nop into M register.
- cc  output  3  current condition codes; bit0=OF, bit1=SF, bit2=ZF.
- M_stat  output  3  registered status.
- M_icode  output  4  registered icode.
- M_ifun  output  4  registered ifun.
- M_cnd  output  1  registered condition.
- M_valE  output  64  registered valE.
- M_valA  output  64  registered valA.
- M_dstE  output  4  registered dstE.
- M_dstM  output  4  registered dstM.

Behaviour:
- All state updates on the rising edge of clk. All outputs are registered; latency from e_* to M_* is 1 cycle.
- Reset (synchronous, highest priority, overrides stall/bubble): cc=3'b100 (ZF=1, SF=0, OF=0). M register loads the bubble values.
- Bubble values: M_stat=AOK, M_icode=1, M_ifun=0, M_cnd=0, M_valE=0, M_valA=0, M_dstE=F, M_dstM=F.
- CC update: set_cc = (e_icode==4'h6) && (m_stat==AOK) && (W_stat==AOK) && !reset.
  - When set_cc is high, cc <= e_newcc on the next edge; otherwise cc holds.
  - M_stall does not gate the CC update.
- dstE squash: the value loaded into M_dstE is F when e_icode==4'h2 && e_cnd==0; otherwise it is e_dstE.
  - rrmovq (ifun 0) always has e_cnd=1 from execute; no special case is required.
- M register priority, highest first: reset, then M_stall (all M_* hold), then M_bubble (load bubble values), then normal load of e_* with the squashed dstE.
- M_stall and M_bubble both high: stall wins and the register holds.
- M_valE and M_valA pass full 64 bits unmodified; no sign or width manipulation.
- A non-AOK e_stat is latched as-is. It does not block its own latch; it blocks CC writes only through m_stat/W_stat on later cycles.
- cc is a pure register output; no combinational path from e_newcc to cc.

Test Plan:
- Reset: assert reset for 1 cycle during an active load → cc=3'b100, M_icode=1, M_dstE=F, M_dstM=F, M_stat=1, M_valE=0.
- OPq subq: e_icode=6, e_ifun=1, e_valE=88, e_newcc=3'b000, m_stat=W_stat=1 → next cycle M_valE=88, cc=3'b000. Repeat with e_newcc=3'b100 → cc=3'b100.
- CC inhibit: e_icode=6, e_newcc=3'b010, m_stat=3 (ADR) → cc unchanged. Same stimulus with W_stat=2 (HLT) → cc unchanged. Both AOK → cc=3'b010.
- cmovle squash: e_icode=2, e_ifun=1, e_cnd=0, e_valE=0x456, e_dstE=3 → M_dstE=F, M_valE=0x456. Same with e_cnd=1 → M_dstE=3.
- cmovg taken: e_icode=2, e_ifun=6, e_cnd=1, e_valE=0x666, e_dstE=5 → M_dstE=5, M_cnd=1.
- Stall/bubble: load e_valE=0x10. Stall 2 cycles with changing inputs → M_valE stays 0x10. Assert stall+bubble together → hold. Bubble alone → M_icode=1, M_dstE=F, M_valE=0. OPq issued during stall with AOK statuses → cc still updates.
